aes_key_schedule: RTL and testbench
===================================

Name: aes_key_schedule

Overview:
AES-128 key-expansion stage that sits directly upstream of the aes round datapath. It accepts one 128-bit cipher key over a valid/ready handshake. It then streams round keys 0..ROUNDS, one per accepted output beat, with the round index, so the round engine can XOR the matching key each cycle. Expansion is iterative: one round key is computed per cycle from the previous one, using the shared sbox function.

Parameters:
ROUNDS, 10, index of the last round key emitted; legal range 1..10 (values below 10 are for reduced-round test only)
ROUND_W, 4, width of the round index; must satisfy 2**ROUND_W > ROUNDS

Ports:
clock  input  1  single clock; all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
key_valid  input  1  key_data is valid
key_ready  output  1  block can accept a new key (high only in IDLE)
key_data  input  128  cipher key, FIPS-197 byte order: key_data[127:120] = byte 0, w0 = key_data[127:96]
rk_valid  output  1  rk_data / rk_round / rk_last are valid
rk_ready  input  1  consumer accepts the current round key
rk_data  output  128  round key, same byte order as key_data
rk_round  output  ROUND_W  index of rk_data, 0..ROUNDS
rk_last  output  1  high when rk_round == ROUNDS and rk_valid is high

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, rk register=0, round=0. Outputs: rk_valid=0, rk_data=0, rk_round=0, rk_last=0, key_ready=1 (IDLE).
- Reset asserted mid-operation aborts the expansion immediately. After release the block is in IDLE and emits nothing until a new key is accepted.
- States are IDLE and RUN. key_ready = (state==IDLE). rk_valid = (state==RUN). All outputs are decoded from registers; there are no combinational paths from any input to any output.
- IDLE: on key_valid && key_ready at edge T, rk <= key_data, round <= 0, state <= RUN. rk_valid is high from T+1 with rk_round=0 and rk_data = key (round key 0 = cipher key).
- RUN: rk_data, rk_round and rk_last are held stable while rk_valid && !rk_ready (no change under backpressure).
- RUN, on rk_valid && rk_ready:
  - If round == ROUNDS: state <= IDLE. key_ready rises on the next cycle; rk_data and rk_round keep their last values with rk_valid=0.
  - Else: round <= round+1, rk <= expand(rk, round+1).
- Throughput with rk_ready held high: keys 0..ROUNDS on cycles T+1..T+ROUNDS+1. key_ready is high again at T+ROUNDS+2. Keys are not accepted back-to-back with the last beat.
- key_valid during RUN is ignored (key_ready=0). The upstream must hold the key until it is accepted.
- expand(k, r), where w0..w3 = k[127:96], k[95:64], k[63:32], k[31:0]:
  - temp = SubWord(RotWord(w3)) ^ {Rcon[r], 24'h0}.
  - RotWord({a,b,c,d}) = {b,c,d,a}. SubWord applies sbox per byte.
  - w4 = w0^temp; w5 = w1^w4; w6 = w2^w5; w7 = w3^w6; result = {w4,w5,w6,w7}.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36 (hex). Rcon is a constant table indexed by round; indices outside 1..10 are never used.
- Round counter never wraps: it saturates at ROUNDS and is cleared only on key acceptance or reset.
- Simultaneous events: key_valid while rk handshake on the last beat has no effect in that cycle; the key is taken in the following IDLE cycle.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - round 0 = the key.
  - round 1 = a0fafe1788542cb123a339392a6c7605.
  - round 2 = f2c295f27a96b9435935807a7359f67f.
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, with rk_last=1.
  - Timing: 11 consecutive valid beats; key_ready high 12 cycles after acceptance.
- Same key, rk_ready toggled randomly (and held low 5 cycles at round 3):
  - rk_data/rk_round stable while stalled.
  - Identical key sequence to the previous scenario; exactly 11 handshakes.
- All-zero key:
  - round 1 = 62636363626363636263636362636363.
  - round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- key_valid asserted with a different key during RUN: ignored, current sequence completes unchanged. Second key accepted only once key_ready returns; its round 0 equals the second key.
- reset_n pulsed low at round 5 with rk_ready=1:
  - Outputs go to reset values asynchronously.
  - After release: rk_valid=0, key_ready=1; a fresh key restarts at round 0.
- Back-to-back keys with key_valid held high: second key accepted exactly 1 cycle after the last-beat handshake of the first; no duplicate or skipped round indices.

Source files
------------

// File: rtl/aes_key_schedule_if.sv
// Key-in / round-key-out handshake bundle for the AES-128 key schedule.
// The slave side is the key schedule; the master side is the key source and the round engine.
interface aes_key_schedule_if #(
  parameter int ROUND_W = 4
);
  logic               key_valid;
  logic               key_ready;
  logic [127:0]       key_data;
  logic               rk_valid;
  logic               rk_ready;
  logic [127:0]       rk_data;
  logic [ROUND_W-1:0] rk_round;
  logic               rk_last;

  modport master (
    output key_valid, key_data, rk_ready,
    input  key_ready, rk_valid, rk_data, rk_round, rk_last
  );

  modport slave (
    input  key_valid, key_data, rk_ready,
    output key_ready, rk_valid, rk_data, rk_round, rk_last
  );
endinterface

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: accepts one cipher key, then streams round keys 0..ROUNDS.
// One round key is derived per accepted output beat from the previous one.
//
// state | meaning
// IDLE  | waiting for a cipher key, key_ready high
// RUN   | presenting round key `round`, rk_valid high, advances on rk_ready
module aes_key_schedule #(
  parameter int ROUNDS  = 10,
  parameter int ROUND_W = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  aes_key_schedule_if.slave   ks
);

  typedef enum logic {IDLE, RUN} state_t;

  // FIPS-197 S-box, row-major: entry x sits at bits [2047-8x -: 8].
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {b, 3'b000};
    return SBOX_TBL[11'd2047 - idx -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [ROUND_W-1:0] r);
    logic [7:0] c;
    c = 8'h00;
    case (r)
      ROUND_W'(1):  c = 8'h01;
      ROUND_W'(2):  c = 8'h02;
      ROUND_W'(3):  c = 8'h04;
      ROUND_W'(4):  c = 8'h08;
      ROUND_W'(5):  c = 8'h10;
      ROUND_W'(6):  c = 8'h20;
      ROUND_W'(7):  c = 8'h40;
      ROUND_W'(8):  c = 8'h80;
      ROUND_W'(9):  c = 8'h1b;
      ROUND_W'(10): c = 8'h36;
      default:      c = 8'h00;
    endcase
    return c;
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] k, input logic [ROUND_W-1:0] r);
    logic [31:0] w0, w1, w2, w3, rot, temp, w4, w5, w6, w7;
    w0   = k[127:96];
    w1   = k[95:64];
    w2   = k[63:32];
    w3   = k[31:0];
    rot  = {w3[23:0], w3[31:24]};
    temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
           ^ {rcon(r), 24'h000000};
    w4   = w0 ^ temp;
    w5   = w1 ^ w4;
    w6   = w2 ^ w5;
    w7   = w3 ^ w6;
    return {w4, w5, w6, w7};
  endfunction

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS);

  state_t             state, state_nxt;
  logic [127:0]       rk, rk_nxt;
  logic [ROUND_W-1:0] round, round_nxt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      rk    <= '0;
      round <= '0;
    end else begin
      state <= state_nxt;
      rk    <= rk_nxt;
      round <= round_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rk_nxt    = rk;
    round_nxt = round;
    case (state)
      IDLE: begin
        if (ks.key_valid) begin
          rk_nxt    = ks.key_data;
          round_nxt = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (ks.rk_ready) begin
          // Last beat leaves rk/round untouched so the bus keeps its final values.
          if (round == LAST_ROUND) begin
            state_nxt = IDLE;
          end else begin
            round_nxt = round + 1'b1;
            rk_nxt    = expand(rk, round + 1'b1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ks.key_ready = (state == IDLE);
  assign ks.rk_valid  = (state == RUN);
  assign ks.rk_data   = rk;
  assign ks.rk_round  = round;
  assign ks.rk_last   = (state == RUN) && (round == LAST_ROUND);

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule against a word-array FIPS-197 key expansion model.
// The model derives its S-box from GF(2^8) inversion plus the affine map.
module tb_aes_key_schedule;

  localparam int ROUNDS  = 10;
  localparam int ROUND_W = 4;

  logic clock;
  logic reset_n;

  aes_key_schedule_if #(.ROUND_W(ROUND_W)) bus ();

  aes_key_schedule #(.ROUNDS(ROUNDS), .ROUND_W(ROUND_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .ks      (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]   sbox_tab [256];
  logic [127:0] cap_data [16];
  int           cap_round [16];
  logic         cap_last [16];
  int           cap_n;
  int           cap_cycles;
  int           viol;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tab[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  // Straight FIPS-197 word recurrence over w[0..43]; returns round key r.
  function automatic logic [127:0] ref_rk(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_key(input logic [127:0] k);
    int n;
    n = 0;
    bus.key_data  = k;
    bus.key_valid = 1'b1;
    while (bus.key_ready !== 1'b1 && n < 50) begin tick(); n++; end
    n_cmp++;
    if (bus.key_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_key_timeout key_ready=%b required=1 after %0d cycles", bus.key_ready, n);
    end
    tick();
    bus.key_valid = 1'b0;
  endtask

  // Records every handshaken beat until the last one; counts protocol violations
  // (outputs changing while stalled, key_ready high or rk_valid low mid-stream).
  task automatic collect(input bit random_ready);
    int cyc, hold;
    bit held, prev_stall, done;
    logic [127:0]         pd;
    logic [ROUND_W-1:0]   pr;
    logic                 pl;
    cyc = 0; hold = 0; held = 0; prev_stall = 0; done = 0;
    cap_n = 0; viol = 0;
    while (!done && cyc < 300) begin
      if (prev_stall && (bus.rk_data !== pd || bus.rk_round !== pr ||
                         bus.rk_last !== pl || bus.rk_valid !== 1'b1)) viol++;
      if (bus.key_ready !== 1'b0 || bus.rk_valid !== 1'b1) viol++;
      if (random_ready) begin
        if (!held && bus.rk_valid === 1'b1 && bus.rk_round == 3) begin hold = 5; held = 1; end
        if (hold > 0) begin bus.rk_ready = 1'b0; hold--; end
        else bus.rk_ready = 1'($urandom_range(0, 1));
      end else begin
        bus.rk_ready = 1'b1;
      end
      if (bus.rk_valid === 1'b1 && bus.rk_ready === 1'b1) begin
        if (cap_n < 16) begin
          cap_data[cap_n]  = bus.rk_data;
          cap_round[cap_n] = int'(bus.rk_round);
          cap_last[cap_n]  = bus.rk_last;
        end
        cap_n++;
        if (bus.rk_last === 1'b1) done = 1;
      end
      prev_stall = (bus.rk_valid === 1'b1) && (bus.rk_ready === 1'b0);
      pd = bus.rk_data; pr = bus.rk_round; pl = bus.rk_last;
      tick();
      cyc++;
    end
    bus.rk_ready = 1'b1;
    cap_cycles = cyc;
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL collect_timeout beats=%0d cycles=%0d required last beat", cap_n, cyc);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if (bus.key_ready !== 1'b1 || bus.rk_valid !== 1'b0 || bus.rk_data !== 128'h0 ||
        bus.rk_round !== '0 || bus.rk_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values key_ready=%b rk_valid=%b rk_data=%h rk_round=%0d rk_last=%b required 1 0 0 0 0",
               bus.key_ready, bus.rk_valid, bus.rk_data, bus.rk_round, bus.rk_last);
    end
  endtask

  task automatic test_fips();
    logic [127:0] exp_k [3];
    exp_k[0] = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_k[1] = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_k[2] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    send_key(FIPS_KEY);
    collect(1'b0);
    n_cmp++;
    if (cap_n !== ROUNDS + 1 || cap_cycles !== ROUNDS + 1 || viol !== 0) begin
      n_fail++;
      $display("FAIL fips_timing beats=%0d cycles=%0d viol=%0d required 11 11 0", cap_n, cap_cycles, viol);
    end
    for (int i = 0; i <= ROUNDS; i++) begin
      n_cmp++;
      if (cap_data[i] !== ref_rk(FIPS_KEY, i) || cap_round[i] !== i || cap_last[i] !== (i == ROUNDS)) begin
        n_fail++;
        $display("FAIL fips_round%0d got %h/%0d/%b required %h/%0d/%b", i, cap_data[i], cap_round[i],
                 cap_last[i], ref_rk(FIPS_KEY, i), i, (i == ROUNDS));
      end
    end
    n_cmp++;
    if (cap_data[0] !== FIPS_KEY || cap_data[1] !== exp_k[0] || cap_data[2] !== exp_k[1] ||
        cap_data[10] !== exp_k[2]) begin
      n_fail++;
      $display("FAIL fips_vectors r0=%h r1=%h r2=%h r10=%h", cap_data[0], cap_data[1], cap_data[2], cap_data[10]);
    end
    n_cmp++;
    if (bus.key_ready !== 1'b1 || bus.rk_valid !== 1'b0 || bus.rk_last !== 1'b0 ||
        bus.rk_data !== exp_k[2] || bus.rk_round !== ROUND_W'(ROUNDS)) begin
      n_fail++;
      $display("FAIL fips_after_last key_ready=%b rk_valid=%b rk_last=%b rk_data=%h rk_round=%0d required 1 0 0 %h 10",
               bus.key_ready, bus.rk_valid, bus.rk_last, bus.rk_data, bus.rk_round, exp_k[2]);
    end
  endtask

  task automatic test_backpressure();
    tick();
    send_key(FIPS_KEY);
    collect(1'b1);
    n_cmp++;
    if (cap_n !== ROUNDS + 1 || viol !== 0) begin
      n_fail++;
      $display("FAIL stall_protocol beats=%0d viol=%0d required 11 0", cap_n, viol);
    end
    for (int i = 0; i <= ROUNDS; i++) begin
      n_cmp++;
      if (cap_data[i] !== ref_rk(FIPS_KEY, i) || cap_round[i] !== i) begin
        n_fail++;
        $display("FAIL stall_round%0d got %h/%0d required %h/%0d", i, cap_data[i], cap_round[i],
                 ref_rk(FIPS_KEY, i), i);
      end
    end
    tick();
    n_cmp++;
    if (bus.rk_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_extra_beat rk_valid=%b required 0", bus.rk_valid);
    end
  endtask

  task automatic test_zero_key();
    send_key(128'h0);
    collect(1'b0);
    n_cmp++;
    if (cap_data[1] !== 128'h62636363626363636263636362636363 ||
        cap_data[10] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
      n_fail++;
      $display("FAIL zero_key r1=%h r10=%h required 62636363626363636263636362636363 b4ef5bcb3e92e21123e951cf6f8f188e",
               cap_data[1], cap_data[10]);
    end
  endtask

  task automatic test_ignore_key_in_run();
    logic [127:0] k1, k2;
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    send_key(k1);
    bus.key_data  = k2;
    bus.key_valid = 1'b1;
    collect(1'b1);
    for (int i = 0; i <= ROUNDS; i++) begin
      n_cmp++;
      if (cap_data[i] !== ref_rk(k1, i) || cap_round[i] !== i) begin
        n_fail++;
        $display("FAIL ignore_round%0d got %h/%0d required %h/%0d", i, cap_data[i], cap_round[i], ref_rk(k1, i), i);
      end
    end
    tick();
    bus.key_valid = 1'b0;
    n_cmp++;
    if (bus.rk_valid !== 1'b1 || bus.rk_round !== '0 || bus.rk_data !== k2) begin
      n_fail++;
      $display("FAIL ignore_second_key rk_valid=%b rk_round=%0d rk_data=%h required 1 0 %h",
               bus.rk_valid, bus.rk_round, bus.rk_data, k2);
    end
    collect(1'b0);
    n_cmp++;
    if (cap_data[ROUNDS] !== ref_rk(k2, ROUNDS)) begin
      n_fail++;
      $display("FAIL ignore_second_r10 got %h required %h", cap_data[ROUNDS], ref_rk(k2, ROUNDS));
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] k;
    int n;
    n = 0;
    send_key({$urandom, $urandom, $urandom, $urandom});
    bus.rk_ready = 1'b1;
    while (bus.rk_round != 5 && n < 20) begin tick(); n++; end
    #3;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.rk_valid !== 1'b0 || bus.rk_data !== 128'h0 || bus.rk_round !== '0 ||
        bus.rk_last !== 1'b0 || bus.key_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_async rk_valid=%b rk_data=%h rk_round=%0d rk_last=%b key_ready=%b required 0 0 0 0 1",
               bus.rk_valid, bus.rk_data, bus.rk_round, bus.rk_last, bus.key_ready);
    end
    tick();
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (bus.rk_valid !== 1'b0 || bus.key_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release rk_valid=%b key_ready=%b required 0 1", bus.rk_valid, bus.key_ready);
    end
    k = {$urandom, $urandom, $urandom, $urandom};
    send_key(k);
    collect(1'b0);
    for (int i = 0; i <= ROUNDS; i++) begin
      n_cmp++;
      if (cap_data[i] !== ref_rk(k, i) || cap_round[i] !== i) begin
        n_fail++;
        $display("FAIL restart_round%0d got %h/%0d required %h/%0d", i, cap_data[i], cap_round[i], ref_rk(k, i), i);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] k1, k2;
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    send_key(k1);
    bus.key_data  = k2;
    bus.key_valid = 1'b1;
    collect(1'b0);
    n_cmp++;
    if (bus.key_ready !== 1'b1 || bus.rk_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap key_ready=%b rk_valid=%b required 1 0", bus.key_ready, bus.rk_valid);
    end
    tick();
    bus.key_valid = 1'b0;
    n_cmp++;
    if (bus.rk_valid !== 1'b1 || bus.rk_round !== '0 || bus.rk_data !== k2) begin
      n_fail++;
      $display("FAIL b2b_accept rk_valid=%b rk_round=%0d rk_data=%h required 1 0 %h",
               bus.rk_valid, bus.rk_round, bus.rk_data, k2);
    end
    collect(1'b0);
    for (int i = 0; i <= ROUNDS; i++) begin
      n_cmp++;
      if (cap_data[i] !== ref_rk(k2, i) || cap_round[i] !== i) begin
        n_fail++;
        $display("FAIL b2b_round%0d got %h/%0d required %h/%0d", i, cap_data[i], cap_round[i], ref_rk(k2, i), i);
      end
    end
  endtask

  task automatic test_random_keys();
    logic [127:0] k;
    for (int t = 0; t < 3; t++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      send_key(k);
      collect(1'b1);
      for (int i = 0; i <= ROUNDS; i++) begin
        n_cmp++;
        if (cap_data[i] !== ref_rk(k, i) || cap_round[i] !== i || cap_last[i] !== (i == ROUNDS)) begin
          n_fail++;
          $display("FAIL random%0d_round%0d got %h/%0d/%b required %h/%0d", t, i, cap_data[i],
                   cap_round[i], cap_last[i], ref_rk(k, i), i);
        end
      end
      n_cmp++;
      if (viol !== 0) begin
        n_fail++;
        $display("FAIL random%0d_protocol viol=%0d required 0", t, viol);
      end
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_data  = '0;
    bus.rk_ready  = 1'b0;
    build_sbox();
    #1;
    test_reset();
    tick();
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    test_fips();
    test_backpressure();
    test_zero_key();
    test_ignore_key_in_run();
    test_reset_mid();
    test_back_to_back();
    test_random_keys();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
